// File: rtl/mult_exhaustive_checker.sv
// Exhaustive stimulus/response checker for an N x N candidate multiplier.
// Scans every (A,B) pair, compares the returned product with the exact one and keeps error statistics.
module mult_exhaustive_checker #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N-1:0]     cand_a,
    output logic [N-1:0]     cand_b,
    input  logic [2*N-1:0]   cand_p,
    output logic             busy,
    output logic             done,
    output logic [2*N:0]     err_count,
    output logic             first_err_valid,
    output logic [N-1:0]     first_err_a,
    output logic [N-1:0]     first_err_b,
    output logic [2*N-1:0]   max_abs_err
);
    localparam int PW = 2 * N;
    localparam int EW = 2 * N + 1;
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   idx_r;
    logic [CW-1:0]   wait_r;
    logic [PW-1:0]   exact_s;
    logic [PW-1:0]   diff_s;
    logic            mismatch_s;

    // Operands come straight from the scan index register, A is the outer loop.
    assign cand_a = idx_r[PW-1:N];
    assign cand_b = idx_r[N-1:0];

    // Exact product and wrap-free absolute difference (larger minus smaller).
    always_comb begin
        exact_s    = {{N{1'b0}}, cand_a} * {{N{1'b0}}, cand_b};
        mismatch_s = (cand_p != exact_s);
        if (cand_p >= exact_s) begin
            diff_s = cand_p - exact_s;
        end else begin
            diff_s = exact_s - cand_p;
        end
    end

    // Scan FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= S_IDLE;
            idx_r           <= {PW{1'b0}};
            wait_r          <= {CW{1'b0}};
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= {EW{1'b0}};
            first_err_valid <= 1'b0;
            first_err_a     <= {N{1'b0}};
            first_err_b     <= {N{1'b0}};
            max_abs_err     <= {PW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        err_count       <= {EW{1'b0}};
                        first_err_valid <= 1'b0;
                        first_err_a     <= {N{1'b0}};
                        first_err_b     <= {N{1'b0}};
                        max_abs_err     <= {PW{1'b0}};
                        idx_r           <= {PW{1'b0}};
                        wait_r          <= {CW{1'b0}};
                        busy            <= 1'b1;
                        state_r         <= S_DRIVE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_DRIVE: begin
                    if (wait_r == CW'(SETTLE)) begin
                        wait_r  <= {CW{1'b0}};
                        state_r <= S_CHECK;
                    end else begin
                        wait_r  <= wait_r + CW'(1);
                    end
                end
                S_CHECK: begin
                    if (mismatch_s) begin
                        err_count <= err_count + EW'(1);
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_a     <= cand_a;
                            first_err_b     <= cand_b;
                        end
                    end
                    if (diff_s > max_abs_err) begin
                        max_abs_err <= diff_s;
                    end
                    if (idx_r == {PW{1'b1}}) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        idx_r   <= idx_r + PW'(1);
                        state_r <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_exhaustive_checker.sv
// Bench for mult_exhaustive_checker: SETTLE=1 instance with a registered candidate and
// SETTLE=0 instance with a combinational candidate, both sharing one fault table.
module tb_mult_exhaustive_checker;
    localparam int N  = 2;
    localparam int PW = 2 * N;
    localparam int NP = 1 << PW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
    logic [N-1:0]  a1_s, b1_s, a0_s, b0_s, fa1_s, fb1_s, fa0_s, fb0_s;
    logic [PW-1:0] p1_s, p0_s, mx1_s, mx0_s;
    logic [PW:0]   ec1_s, ec0_s;
    logic          busy1_s, done1_s, busy0_s, done0_s, fv1_s, fv0_s;

    logic          f_en  [NP];
    logic [PW-1:0] f_val [NP];

    int chk_cnt = 0;
    int err_cnt = 0;

    mult_exhaustive_checker #(.N(N), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .cand_a(a1_s), .cand_b(b1_s), .cand_p(p1_s),
        .busy(busy1_s), .done(done1_s), .err_count(ec1_s), .first_err_valid(fv1_s),
        .first_err_a(fa1_s), .first_err_b(fb1_s), .max_abs_err(mx1_s)
    );

    mult_exhaustive_checker #(.N(N), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .cand_a(a0_s), .cand_b(b0_s), .cand_p(p0_s),
        .busy(busy0_s), .done(done0_s), .err_count(ec0_s), .first_err_valid(fv0_s),
        .first_err_a(fa0_s), .first_err_b(fb0_s), .max_abs_err(mx0_s)
    );

    // Candidate with one register stage, valid after SETTLE=1 cycle.
    always @(posedge clk)
        p1_s <= f_en[{a1_s, b1_s}] ? f_val[{a1_s, b1_s}] : PW'(a1_s) * PW'(b1_s);

    // Purely combinational candidate for the SETTLE=0 instance.
    always_comb begin
        p0_s = f_en[{a0_s, b0_s}] ? f_val[{a0_s, b0_s}] : PW'(a0_s) * PW'(b0_s);
    end

    task automatic check_val(input string tag, input longint act, input longint exp);
        chk_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < NP; i++) begin
            f_en[i]  = 1'b0;
            f_val[i] = '0;
        end
    endtask

    task automatic set_fault(input int a, input int b, input int val);
        f_en[a * (1 << N) + b]  = 1'b1;
        f_val[a * (1 << N) + b] = PW'(val);
    endtask

    // Reference: walk the pairs in scan order using plain integer arithmetic.
    task automatic compute_expected(output int ec, output int fv, output int fa,
                                    output int fb, output int mx);
        int exact, got, d;
        ec = 0; fv = 0; fa = 0; fb = 0; mx = 0;
        for (int a = 0; a < (1 << N); a++) begin
            for (int b = 0; b < (1 << N); b++) begin
                exact = a * b;
                got   = f_en[a * (1 << N) + b] ? int'(f_val[a * (1 << N) + b]) : exact;
                if (got != exact) begin
                    ec++;
                    if (fv == 0) begin
                        fv = 1; fa = a; fb = b;
                    end
                end
                d = (got > exact) ? got - exact : exact - got;
                if (d > mx) mx = d;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_busy1"}, busy1_s, 0); check_val({tag, "_done1"}, done1_s, 0);
        check_val({tag, "_ec1"}, ec1_s, 0);     check_val({tag, "_fv1"}, fv1_s, 0);
        check_val({tag, "_fa1"}, fa1_s, 0);     check_val({tag, "_fb1"}, fb1_s, 0);
        check_val({tag, "_mx1"}, mx1_s, 0);     check_val({tag, "_a1"}, a1_s, 0);
        check_val({tag, "_b1"}, b1_s, 0);
        check_val({tag, "_busy0"}, busy0_s, 0); check_val({tag, "_done0"}, done0_s, 0);
        check_val({tag, "_ec0"}, ec0_s, 0);     check_val({tag, "_fv0"}, fv0_s, 0);
        check_val({tag, "_mx0"}, mx0_s, 0);     check_val({tag, "_a0"}, a0_s, 0);
    endtask

    // One full scan; optionally re-pulse start at cycle 'repulse' while busy.
    task automatic run_scan(input string tag, input int repulse);
        int bz1 = 0, bz0 = 0, dn1 = 0, dn0 = 0, dc1 = 0, dc0 = 0;
        int ec, fv, fa, fb, mx;
        compute_expected(ec, fv, fa, fb, mx);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            if (busy1_s) bz1++;
            if (busy0_s) bz0++;
            if (done1_s) begin dn1++; dc1 = c; end
            if (done0_s) begin dn0++; dc0 = c; end
            start = (c == repulse) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        check_val({tag, "_busycyc1"}, bz1, NP * 3);
        check_val({tag, "_busycyc0"}, bz0, NP * 2);
        check_val({tag, "_ndone1"}, dn1, 1);
        check_val({tag, "_ndone0"}, dn0, 1);
        check_val({tag, "_donecyc1"}, dc1, NP * 3 + 1);
        check_val({tag, "_donecyc0"}, dc0, NP * 2 + 1);
        check_val({tag, "_ec1"}, ec1_s, ec); check_val({tag, "_ec0"}, ec0_s, ec);
        check_val({tag, "_fv1"}, fv1_s, fv); check_val({tag, "_fv0"}, fv0_s, fv);
        check_val({tag, "_fa1"}, fa1_s, fa); check_val({tag, "_fa0"}, fa0_s, fa);
        check_val({tag, "_fb1"}, fb1_s, fb); check_val({tag, "_fb0"}, fb0_s, fb);
        check_val({tag, "_mx1"}, mx1_s, mx); check_val({tag, "_mx0"}, mx0_s, mx);
    endtask

    task automatic reset_mid_scan();
        int dn = 0, bz = 0;
        clear_faults();
        for (int i = 0; i < NP; i++) set_fault(i / (1 << N), i % (1 << N), 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c < 23; c++) @(negedge clk);
        check_val("mid_a_idx7", a1_s, 1);
        check_val("mid_b_idx7", b1_s, 3);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (done1_s || done0_s) dn++;
            if (busy1_s || busy0_s) bz++;
            @(negedge clk);
        end
        check_val("midrst_nodone", dn, 0);
        check_val("midrst_nobusy", bz, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear_faults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        clear_faults();
        run_scan("exact", 0);

        for (int i = 0; i < NP; i++) set_fault(i / (1 << N), i % (1 << N), 0);
        run_scan("stuck0", 0);

        clear_faults();
        set_fault(2, 3, 4);
        run_scan("single", 0);

        clear_faults();
        set_fault(3, 3, 15);
        set_fault(1, 2, 0);
        run_scan("double", 0);

        reset_mid_scan();
        clear_faults();
        set_fault(3, 1, 7);
        run_scan("afterrst", 0);

        clear_faults();
        run_scan("repulse", 10);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NP; i++) begin
                f_en[i]  = ($urandom_range(0, 3) == 0);
                f_val[i] = PW'($urandom_range(0, NP - 1));
            end
            run_scan($sformatf("rand%0d", r), 0);
        end

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end
endmodule
